multicycle_ctrl_fsm: RTL and testbench
======================================

# multicycle_ctrl_fsm

Main control state machine for the multicycle RV32I core. Sequences fetch, decode, execute, memory and writeback over several cycles, so one ALU, one memory port and the immediate extender serve every step. Drives the datapath mux selects and write enables, plus `imm_src` for the extender. Sits between the instruction register's opcode field and the datapath; ALU-function decoding from funct3/funct7 is done elsewhere.

## Interface
- No parameters.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `op` in 7: opcode, Instr[6:0], from the instruction register.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory access completes this cycle.
- `mem_req` out 1: memory access active.
- `adr_src` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `ir_write`, `pc_write`, `mem_write`, `reg_write` out 1 each: write enables.
- `alu_src_a` out 2: 00 PC, 01 OldPC, 10 RD1.
- `alu_src_b` out 2: 00 RD2, 01 ImmExt, 10 constant 4.
- `alu_op` out 2: 00 add, 01 subtract, 10 use funct.
- `result_src` out 2: 00 ALUOut, 01 read data, 10 ALUResult.
- `imm_src` out 2: 00 I-type, 01 S-type, 10 B-type; 11 is never driven.
- `instr_retired` out 1: one-cycle pulse on the final cycle of each instruction.
- `illegal_instr` out 1: sticky flag; only exists with the macro in Configuration.

## Operation
- States and outputs (outputs not listed are 0):
  - FETCH: `mem_req`, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=00, `result_src`=10. `ir_write` and `pc_write` = `mem_ready`. Stays in FETCH until `mem_ready`, then goes to DECODE.
  - DECODE: `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00 (computes the branch target). Next state by opcode:
    - 0000011 (lw) or 0100011 (sw) → MEMADR
    - 0110011 (R-type) → EXEC_R
    - 0010011 (I-type ALU) → EXEC_I
    - 1100011 (beq) → BEQ
    - any other opcode → see Configuration
  - MEMADR: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00. Goes to MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: `mem_req`, `adr_src`=1. Waits for `mem_ready`, then goes to MEMWB.
  - MEMWB: `result_src`=01, `reg_write`, `instr_retired`. Next: FETCH.
  - MEMWRITE: `mem_req`, `adr_src`=1, `mem_write` held for the whole wait. On `mem_ready`: `instr_retired`, next FETCH.
  - EXEC_R: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10. Next: ALUWB.
  - EXEC_I: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10. Next: ALUWB.
  - ALUWB: `result_src`=00, `reg_write`, `instr_retired`. Next: FETCH.
  - BEQ: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00, `pc_write`=`zero`, `instr_retired`. Next: FETCH.
- `imm_src` is decoded combinationally from `op` in every state:
  - sw → 01
  - beq → 10
  - all other opcodes → 00
- funct3 is not inspected; every 1100011 opcode is treated as beq.
- `mem_ready` is ignored outside FETCH, MEMREAD and MEMWRITE.

## Timing
- Outputs are Moore decodes of the state register, plus `op` (for `imm_src`), `mem_ready` and `zero` where noted above.
- Reset:
  - `rst_n` low at a rising edge puts the state in FETCH and clears `illegal_instr`.
  - While `rst_n` is low, `pc_write`, `ir_write`, `mem_write`, `reg_write`, `mem_req` and `instr_retired` are forced to 0, whatever the current state.
- Reset mid-instruction abandons the instruction with no write. A `mem_write` that is in progress drops in the same cycle `rst_n` goes low.
- Cycles per instruction with zero-wait memory:
  - lw: 5
  - sw: 4
  - R-type and I-type: 4
  - beq: 3
- Each wait cycle (`mem_ready` low in FETCH, MEMREAD or MEMWRITE) adds 1 cycle.
- `instr_retired` is high for exactly one cycle per completed instruction.

## Configuration
- Macro `CTRL_ILLEGAL_TRAP_EN`.
- Defined: an unknown opcode in DECODE moves to state TRAP.
  - TRAP holds forever with all enables 0.
  - `illegal_instr` is set on entry to TRAP and stays set until reset.
- Undefined: an unknown opcode returns to FETCH as a NOP.
  - `instr_retired` pulses in DECODE.
  - The `illegal_instr` port does not exist.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - the state enum
  - the opcode constants
  - the `alu_src_a`, `alu_src_b`, `result_src`, `alu_op` and `imm_src` encodings; the `imm_src` encoding is shared with the extender
- Sub-module `ctrl_out_decode`: combinational state-to-outputs decode. The top level keeps the state register and next-state logic.

## Test plan
- Reset:
  - Hold `rst_n` low for 2 cycles with `mem_ready`=1 → all enables 0 and state is FETCH.
  - Release reset → `ir_write`=`pc_write`=1 in the first cycle.
- lw, zero-wait: `op`=0000011 → state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. `imm_src`=00; `reg_write` and `result_src`=01 in cycle 5.
- sw with 2 wait cycles: `op`=0100011 → `mem_write` high for 3 consecutive cycles, `imm_src`=01, 6 cycles total.
- beq:
  - `op`=1100011, `zero`=1 in the BEQ cycle → `pc_write`=1, `imm_src`=10.
  - Repeat with `zero`=0 → `pc_write`=0 while `instr_retired` still pulses.
- R-type then I-type back-to-back → `alu_op`=10 in both execute cycles; `alu_src_b`=00 for R-type, 01 for I-type; 8 cycles total.
- Unknown opcode 1111111:
  - With `CTRL_ILLEGAL_TRAP_EN` → `illegal_instr`=1 and no further `ir_write` until reset.
  - Without it → the next FETCH starts at cycle 3.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle RV32I main controller: state enum,
// opcode constants, datapath select encodings and the control bundle.
// The imm_src encoding is also consumed by the immediate extender.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BEQ, S_TRAP
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic       instr_retired;
  } ctrl_t;

  // Extender format from opcode; only stores and branches differ from I-type.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    if (op == OP_SW)       return IMM_S;
    else if (op == OP_BEQ) return IMM_B;
    else                   return IMM_I;
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
           (op == OP_I)  || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Controller <-> datapath bundle. master = controller, slave = datapath.
// Optional macro: CTRL_ILLEGAL_TRAP_EN adds the sticky illegal_instr flag.
interface multicycle_ctrl_fsm_if;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] result_src;
  logic [1:0] imm_src;
  logic       instr_retired;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       illegal_instr;
`endif

  modport master (
    input  op, zero, mem_ready,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output illegal_instr,
`endif
    output mem_req, adr_src, ir_write, pc_write, mem_write, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, imm_src, instr_retired
  );

  modport slave (
    output op, zero, mem_ready,
`ifdef CTRL_ILLEGAL_TRAP_EN
    input  illegal_instr,
`endif
    input  mem_req, adr_src, ir_write, pc_write, mem_write, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, imm_src, instr_retired
  );
endinterface

// File: rtl/multicycle_ctrl_fsm_ctrl_out_decode.sv
// Combinational state -> control decode. Moore outputs plus the few
// mem_ready/zero/op qualified terms; write enables are killed in reset.
// Optional macro: CTRL_ILLEGAL_TRAP_EN (unknown opcodes trap instead of NOP).
module ctrl_out_decode
  import riscv_ctrl_pkg::*;
(
  input  state_e     i_state,
  input  logic       i_rst_n,
  input  logic       i_mem_ready,
  input  logic       i_zero,
  input  logic [6:0] i_op,
  output ctrl_t      o_ctrl
);
  ctrl_t w_c;

  // Per-state control decode, then reset gating of all enables
  always_comb begin
    w_c         = '0;
    w_c.imm_src = imm_src_of(i_op);
    case (i_state)
      S_FETCH: begin
        w_c.mem_req    = 1'b1;
        w_c.alu_src_a  = SRCA_PC;
        w_c.alu_src_b  = SRCB_FOUR;
        w_c.alu_op     = ALUOP_ADD;
        w_c.result_src = RES_ALURESULT;
        w_c.ir_write   = i_mem_ready;
        w_c.pc_write   = i_mem_ready;
      end
      S_DECODE: begin
        w_c.alu_src_a = SRCA_OLDPC;
        w_c.alu_src_b = SRCB_IMM;
`ifndef CTRL_ILLEGAL_TRAP_EN
        // unknown opcode is a one-cycle NOP that retires here
        w_c.instr_retired = !is_legal(i_op);
`endif
      end
      S_MEMADR: begin
        w_c.alu_src_a = SRCA_RD1;
        w_c.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        w_c.mem_req = 1'b1;
        w_c.adr_src = 1'b1;
      end
      S_MEMWB: begin
        w_c.result_src    = RES_READDATA;
        w_c.reg_write     = 1'b1;
        w_c.instr_retired = 1'b1;
      end
      S_MEMWRITE: begin
        w_c.mem_req       = 1'b1;
        w_c.adr_src       = 1'b1;
        w_c.mem_write     = 1'b1;
        w_c.instr_retired = i_mem_ready;
      end
      S_EXEC_R: begin
        w_c.alu_src_a = SRCA_RD1;
        w_c.alu_src_b = SRCB_RD2;
        w_c.alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        w_c.alu_src_a = SRCA_RD1;
        w_c.alu_src_b = SRCB_IMM;
        w_c.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        w_c.result_src    = RES_ALUOUT;
        w_c.reg_write     = 1'b1;
        w_c.instr_retired = 1'b1;
      end
      S_BEQ: begin
        w_c.alu_src_a     = SRCA_RD1;
        w_c.alu_src_b     = SRCB_RD2;
        w_c.alu_op        = ALUOP_SUB;
        w_c.result_src    = RES_ALUOUT;
        w_c.pc_write      = i_zero;
        w_c.instr_retired = 1'b1;
      end
      default: ; // TRAP: everything stays 0
    endcase
    if (!i_rst_n) begin
      w_c.mem_req       = 1'b0;
      w_c.ir_write      = 1'b0;
      w_c.pc_write      = 1'b0;
      w_c.mem_write     = 1'b0;
      w_c.reg_write     = 1'b0;
      w_c.instr_retired = 1'b0;
    end
  end

  assign o_ctrl = w_c;
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle RV32I core: owns the state register and
// next-state logic; output decode lives in ctrl_out_decode.
// Optional macro: CTRL_ILLEGAL_TRAP_EN (unknown opcode -> TRAP + illegal_instr).
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_ctrl_fsm_if.master  bus
);
  state_e r_state;
  ctrl_t  w_ctrl;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic   r_illegal;
`endif

  // State register and next-state sequencing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
      r_illegal <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_FETCH:    if (bus.mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (bus.op)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_R:         r_state <= S_EXEC_R;
            OP_I:         r_state <= S_EXEC_I;
            OP_BEQ:       r_state <= S_BEQ;
            default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
              r_state   <= S_TRAP;
              r_illegal <= 1'b1;
`else
              r_state   <= S_FETCH;
`endif
            end
          endcase
        end
        S_MEMADR:   r_state <= (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (bus.mem_ready) r_state <= S_MEMWB;
        S_MEMWRITE: if (bus.mem_ready) r_state <= S_FETCH;
        S_EXEC_R,
        S_EXEC_I:   r_state <= S_ALUWB;
        S_MEMWB,
        S_ALUWB,
        S_BEQ:      r_state <= S_FETCH;
        S_TRAP:     r_state <= S_TRAP;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  ctrl_out_decode u_dec (
    .i_state     (r_state),
    .i_rst_n     (rst_n),
    .i_mem_ready (bus.mem_ready),
    .i_zero      (bus.zero),
    .i_op        (bus.op),
    .o_ctrl      (w_ctrl)
  );

  assign bus.mem_req       = w_ctrl.mem_req;
  assign bus.adr_src       = w_ctrl.adr_src;
  assign bus.ir_write      = w_ctrl.ir_write;
  assign bus.pc_write      = w_ctrl.pc_write;
  assign bus.mem_write     = w_ctrl.mem_write;
  assign bus.reg_write     = w_ctrl.reg_write;
  assign bus.alu_src_a     = w_ctrl.alu_src_a;
  assign bus.alu_src_b     = w_ctrl.alu_src_b;
  assign bus.alu_op        = w_ctrl.alu_op;
  assign bus.result_src    = w_ctrl.result_src;
  assign bus.imm_src       = w_ctrl.imm_src;
  assign bus.instr_retired = w_ctrl.instr_retired;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign bus.illegal_instr = r_illegal;
`endif
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm. An instruction stream feeds a
// behavioural memory responder and IR model; per-instruction expectations
// (cycle count, write-enable counts, imm_src/result_src at retire) are queued
// at issue time and checked by a monitor on each instr_retired.
module tb_multicycle_ctrl_fsm;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BQ = 7'b1100011;

  typedef struct { logic [6:0] op; logic zero; int fw; int dw; } instr_t;
  typedef struct { int cyc; int pw; int iw; int mw; int rw; int imm; int res; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if u_if ();
  multicycle_ctrl_fsm dut (.clk(clk), .rst_n(rst_n), .bus(u_if.master));

  instr_t instr_q[$];
  int     wait_q[$];
  exp_t   exp_q[$];
  int     nvec = 0;
  int     nerr = 0;
  bit     mon_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_mem(input logic [6:0] op);
    return (op == LW) || (op == SW);
  endfunction

  // What an instruction should cost and do, straight from the ISA-level rules
  function automatic exp_t model(input instr_t r);
    exp_t e;
    e.iw = 1; e.pw = 1; e.mw = 0; e.rw = 0; e.imm = 0; e.res = 0;
    case (r.op)
      LW:      begin e.cyc = 5; e.rw = 1; e.res = 1; end
      SW:      begin e.cyc = 4; e.mw = r.dw + 1; e.imm = 1; end
      RT, IT:  begin e.cyc = 4; e.rw = 1; end
      BQ:      begin e.cyc = 3; e.pw = r.zero ? 2 : 1; e.imm = 2; end
      default: e.cyc = 2;
    endcase
    e.cyc += r.fw + (is_mem(r.op) ? r.dw : 0);
    return e;
  endfunction

  task automatic issue(input logic [6:0] op, input logic z, input int fw, input int dw);
    instr_t r;
    r.op = op; r.zero = z; r.fw = fw; r.dw = dw;
    instr_q.push_back(r);
    wait_q.push_back(fw);
    if (is_mem(op)) wait_q.push_back(dw);
    exp_q.push_back(model(r));
  endtask

  task automatic wait_neg();
    @(negedge clk); #2;
  endtask

  function automatic int enables();
    return int'({u_if.pc_write, u_if.ir_write, u_if.mem_write,
                 u_if.reg_write, u_if.mem_req, u_if.instr_retired});
  endfunction

  // Memory responder: each access takes its queued number of wait cycles
  initial begin
    int w; int cnt; bit active;
    w = 0; cnt = 0; active = 1'b0;
    u_if.mem_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        u_if.mem_ready = 1'b1;
        active = 1'b0;
      end else if (u_if.mem_req) begin
        if (!active) begin
          w = (wait_q.size() > 0) ? wait_q.pop_front() : 1000000;
          cnt = 0;
          active = 1'b1;
        end
        u_if.mem_ready = (cnt == w);
        cnt++;
        if (cnt > w) active = 1'b0;
      end else begin
        u_if.mem_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Instruction register: loads the next instruction when ir_write is seen
  initial begin
    bit ld; instr_t r;
    u_if.op = 7'd0; u_if.zero = 1'b0;
    forever begin
      @(negedge clk); #1;
      ld = u_if.ir_write;
      @(posedge clk); #1;
      if (ld && instr_q.size() > 0) begin
        r = instr_q.pop_front();
        u_if.op = r.op;
        u_if.zero = r.zero;
      end
    end
  end

  // Monitor: accumulate per-instruction activity, compare on retirement
  initial begin
    int cyc, pw, iw, mw, rw; exp_t e;
    cyc = 0; pw = 0; iw = 0; mw = 0; rw = 0;
    forever begin
      wait_neg();
      if (!rst_n || !mon_en) begin
        cyc = 0; pw = 0; iw = 0; mw = 0; rw = 0;
      end else begin
        cyc++;
        pw += int'(u_if.pc_write);  iw += int'(u_if.ir_write);
        mw += int'(u_if.mem_write); rw += int'(u_if.reg_write);
        if (u_if.instr_retired) begin
          if (exp_q.size() == 0) check("unexpected_retire", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("cycles", cyc, e.cyc);
            check("pc_write_cnt", pw, e.pw);
            check("ir_write_cnt", iw, e.iw);
            check("mem_write_cnt", mw, e.mw);
            check("reg_write_cnt", rw, e.rw);
            check("imm_src", int'(u_if.imm_src), e.imm);
            check("result_src", int'(u_if.result_src), e.res);
          end
          cyc = 0; pw = 0; iw = 0; mw = 0; rw = 0;
        end
      end
    end
  end

  initial begin
    int t; int cnt; logic [6:0] op;
    // reset held 2 cycles with mem_ready=1: no enable may assert
    rst_n = 1'b0;
    repeat (2) begin wait_neg(); check("reset_enables", enables(), 0); end

    // directed plan items first, then a random stream
    issue(LW, 1'b0, 0, 0);
    issue(SW, 1'b0, 0, 2);
    issue(BQ, 1'b1, 0, 0);
    issue(BQ, 1'b0, 0, 0);
    issue(RT, 1'b0, 0, 0);
    issue(IT, 1'b0, 0, 0);
`ifndef CTRL_ILLEGAL_TRAP_EN
    issue(7'h7F, 1'b0, 0, 0);
`endif
    for (int i = 0; i < 40; i++) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      case ($urandom_range(0, 4))
`else
      case ($urandom_range(0, 6))
`endif
        0: op = LW; 1: op = SW; 2: op = RT; 3: op = IT; 4: op = BQ;
        5: op = 7'h7F;
        default: op = 7'($urandom());
      endcase
      issue(op, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    mon_en = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    wait_neg();
    check("first_fetch_ir_pc", int'({u_if.ir_write, u_if.pc_write}), 3);
    check("first_fetch_adr_src", int'(u_if.adr_src), 0);

    t = 0;
    while (exp_q.size() > 0 && t < 5000) begin wait_neg(); t++; end
    check("drain_left", exp_q.size(), 0);
    wait_neg();
    mon_en = 1'b0;

    // reset while stalled in FETCH: enables drop with the reset level
    @(negedge clk); #3 rst_n = 1'b0;
    #1 check("reset_in_fetch", enables(), 0);
    @(posedge clk); @(negedge clk); #2;
    instr_q.delete(); wait_q.delete(); exp_q.delete();
    issue(SW, 1'b0, 0, 20);
    @(posedge clk); #1 rst_n = 1'b1;

    // abort a long sw: mem_write must drop in the cycle reset goes low
    t = 0;
    do begin wait_neg(); t++; end while (!u_if.mem_write && t < 50);
    check("sw_mem_write_seen", int'(u_if.mem_write), 1);
    #1 rst_n = 1'b0;
    #1 check("abort_mem_write", int'(u_if.mem_write), 0);
    check("abort_enables", enables(), 0);
    @(posedge clk); @(negedge clk); #2;
    instr_q.delete(); wait_q.delete(); exp_q.delete();
    issue(LW, 1'b0, 0, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_neg();
    check("after_abort_fetch", int'({u_if.ir_write, u_if.mem_write, u_if.reg_write}), 4);

`ifdef CTRL_ILLEGAL_TRAP_EN
    @(negedge clk); #3 rst_n = 1'b0;
    @(posedge clk); @(negedge clk); #2;
    instr_q.delete(); wait_q.delete(); exp_q.delete();
    issue(7'h7F, 1'b0, 0, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin wait_neg(); cnt += int'(u_if.ir_write); end
    check("trap_ir_write_cnt", cnt, 1);
    check("trap_illegal", int'(u_if.illegal_instr), 1);
    @(negedge clk); #3 rst_n = 1'b0;
    @(posedge clk); #1;
    check("trap_cleared", int'(u_if.illegal_instr), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
